// File: rtl/key_bcd_counter.sv
// rtl/key_bcd_counter.sv - debounced pushbutton driving a BCD up/down counter with switch load (optional KEY_BCD_AUTOREPEAT_EN)
module key_bcd_counter #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int DIGITS          = 2
) (
    input  logic                  CLOCK_50,
    input  logic                  RESET_N,
    input  logic                  KEY_N,
    input  logic                  UP,
    input  logic                  LOAD,
    input  logic [4*DIGITS-1:0]   LOAD_VAL,
    output logic [4*DIGITS-1:0]   DIGIT,
    output logic                  STEP,
    output logic                  WRAP
);

    localparam int            CW     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] C_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] C_ONE  = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE_HIGH = 2'd0,
        S_WAIT_LOW  = 2'd1,
        S_IDLE_LOW  = 2'd2,
        S_WAIT_HIGH = 2'd3
    } deb_state_t;

    logic                r_sync1;
    logic                r_sync2;
    logic                w_ks;

    deb_state_t          r_state;
    deb_state_t          w_state_nxt;
    logic [CW-1:0]       r_cnt;
    logic [CW-1:0]       w_cnt_nxt;
    logic                w_deb_press;
    logic                w_rep_fire;
    logic                w_press_nxt;
    logic                r_press;

    logic [4*DIGITS-1:0] r_digit;
    logic                r_step;
    logic                r_wrap;
    logic [4*DIGITS-1:0] w_inc;
    logic [4*DIGITS-1:0] w_dec;
    logic [4*DIGITS-1:0] w_clamp;
    logic                w_inc_co;
    logic                w_dec_bo;

    // Two-flop synchroniser; idles high so reset looks like a released key
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= KEY_N;
            r_sync2 <= r_sync1;
        end
    end

    assign w_ks = r_sync2;

    // Debounce state register; press is registered so it lines up with IDLE_LOW entry
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= S_IDLE_HIGH;
            r_cnt   <= '0;
            r_press <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_press <= w_press_nxt;
        end
    end

    // Debounce next-state: a new level must stay put for DEBOUNCE_CYCLES samples
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE_HIGH: begin
                w_cnt_nxt = '0;
                if (!w_ks) begin
                    w_state_nxt = S_WAIT_LOW;
                    w_cnt_nxt   = C_ONE;
                end
            end
            S_WAIT_LOW: begin
                if (w_ks) begin
                    w_state_nxt = S_IDLE_HIGH;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == C_LAST) begin
                    w_state_nxt = S_IDLE_LOW;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + C_ONE;
                end
            end
            S_IDLE_LOW: begin
                w_cnt_nxt = '0;
                if (w_ks) begin
                    w_state_nxt = S_WAIT_HIGH;
                    w_cnt_nxt   = C_ONE;
                end
            end
            S_WAIT_HIGH: begin
                if (!w_ks) begin
                    w_state_nxt = S_IDLE_LOW;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == C_LAST) begin
                    w_state_nxt = S_IDLE_HIGH;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + C_ONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE_HIGH;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Debounce outputs: press only on the accepted falling level, never on release
    always_comb begin
        w_deb_press = (r_state == S_WAIT_LOW) && !w_ks && (r_cnt == C_LAST);
        w_press_nxt = w_deb_press || w_rep_fire;
    end

`ifdef KEY_BCD_AUTOREPEAT_EN
    localparam int            REP_CYCLES = 8 * DEBOUNCE_CYCLES;
    localparam int            RW         = $clog2(REP_CYCLES);
    localparam logic [RW-1:0] REP_LAST   = RW'(REP_CYCLES - 1);

    logic [RW-1:0] r_rep_cnt;
    logic          w_rep_stay;

    assign w_rep_stay = (r_state == S_IDLE_LOW) && (w_state_nxt == S_IDLE_LOW);
    assign w_rep_fire = w_rep_stay && !LOAD && (r_rep_cnt == REP_LAST);

    // Repeat timer runs from the original press while the key stays down
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_rep_cnt <= '0;
        end else if (!w_rep_stay || LOAD || w_rep_fire) begin
            r_rep_cnt <= '0;
        end else begin
            r_rep_cnt <= r_rep_cnt + RW'(1);
        end
    end
`else
    assign w_rep_fire = 1'b0;
`endif

    // BCD increment chain; carry out of the top digit means the count wrapped
    always_comb begin : p_inc
        logic v_c;
        v_c   = 1'b1;
        w_inc = r_digit;
        for (int i = 0; i < DIGITS; i++) begin
            if (v_c) begin
                if (r_digit[4*i +: 4] >= 4'd9) begin
                    w_inc[4*i +: 4] = 4'd0;
                    v_c             = 1'b1;
                end else begin
                    w_inc[4*i +: 4] = r_digit[4*i +: 4] + 4'd1;
                    v_c             = 1'b0;
                end
            end
        end
        w_inc_co = v_c;
    end

    // BCD decrement chain; borrow out of the top digit means the count wrapped
    always_comb begin : p_dec
        logic v_b;
        v_b   = 1'b1;
        w_dec = r_digit;
        for (int i = 0; i < DIGITS; i++) begin
            if (v_b) begin
                if (r_digit[4*i +: 4] == 4'd0) begin
                    w_dec[4*i +: 4] = 4'd9;
                    v_b             = 1'b1;
                end else begin
                    w_dec[4*i +: 4] = r_digit[4*i +: 4] - 4'd1;
                    v_b             = 1'b0;
                end
            end
        end
        w_dec_bo = v_b;
    end

    // Switch values above 9 are clamped so DIGIT never shows a non-BCD nibble
    always_comb begin
        w_clamp = LOAD_VAL;
        for (int i = 0; i < DIGITS; i++) begin
            if (LOAD_VAL[4*i +: 4] > 4'd9) begin
                w_clamp[4*i +: 4] = 4'd9;
            end
        end
    end

    // Count register: LOAD wins over a coincident press
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_digit <= '0;
            r_step  <= 1'b0;
            r_wrap  <= 1'b0;
        end else if (LOAD) begin
            r_digit <= w_clamp;
            r_step  <= 1'b0;
            r_wrap  <= 1'b0;
        end else if (r_press) begin
            r_digit <= UP ? w_inc : w_dec;
            r_step  <= 1'b1;
            r_wrap  <= UP ? w_inc_co : w_dec_bo;
        end else begin
            r_step  <= 1'b0;
            r_wrap  <= 1'b0;
        end
    end

    assign DIGIT = r_digit;
    assign STEP  = r_step;
    assign WRAP  = r_wrap;

endmodule

// File: tb/tb_key_bcd_counter.sv
// tb/tb_key_bcd_counter.sv - directed-vector bench for key_bcd_counter
module tb_key_bcd_counter;

    logic       clk;
    logic       rst_n;
    logic       key_n;
    logic       up;
    logic       load;
    logic [7:0] load_val;
    logic [7:0] digit;
    logic       step;
    logic       wrap;

    int n_vec;
    int n_err;

    key_bcd_counter #(
        .DEBOUNCE_CYCLES(4),
        .DIGITS         (2)
    ) dut (
        .CLOCK_50(clk),
        .RESET_N (rst_n),
        .KEY_N   (key_n),
        .UP      (up),
        .LOAD    (load),
        .LOAD_VAL(load_val),
        .DIGIT   (digit),
        .STEP    (step),
        .WRAP    (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [7:0] v);
        load_val = v;
        load     = 1'b1;
        tick();
        load     = 1'b0;
    endtask

    task automatic do_press(output int steps, output int wraps);
        steps = 0;
        wraps = 0;
        key_n = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (step === 1'b1) steps++;
            if (wrap === 1'b1) wraps++;
        end
        key_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (step === 1'b1) steps++;
            if (wrap === 1'b1) wraps++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick();
        tick();
        n_vec++;
        if (digit !== 8'h00 || step !== 1'b0 || wrap !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: digit=%h step=%b wrap=%b, want 00 0 0", digit, step, wrap);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_async_reset;
        do_load(8'h37);
        n_vec++;
        if (digit !== 8'h37) begin
            n_err++;
            $display("FAIL load_37: digit=%h want 37", digit);
        end
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if (digit !== 8'h00 || step !== 1'b0 || wrap !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: digit=%h step=%b wrap=%b, want 00 0 0", digit, step, wrap);
        end
        #1 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_press;
        up    = 1'b1;
        key_n = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            n_vec++;
            if (step !== (k == 7)) begin
                n_err++;
                $display("FAIL press_step_c%0d: step=%b want %b", k, step, (k == 7));
            end
            if (k == 7) begin
                n_vec++;
                if (digit !== 8'h01) begin
                    n_err++;
                    $display("FAIL press_digit: digit=%h want 01", digit);
                end
            end
        end
        key_n = 1'b1;
        for (int k = 0; k < 16; k++) begin
            tick();
            n_vec++;
            if (step !== 1'b0) begin
                n_err++;
                $display("FAIL release_no_step_c%0d: step=%b want 0", k, step);
            end
        end
    endtask

    task automatic test_bounce;
        logic [3:0] pat;
        pat = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            key_n = pat[k];
            tick();
        end
        key_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            n_vec++;
            if (step !== 1'b0) begin
                n_err++;
                $display("FAIL bounce_step_c%0d: step=%b want 0", k, step);
            end
        end
        key_n = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        key_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            n_vec++;
            if (step !== 1'b0) begin
                n_err++;
                $display("FAIL short_low_step_c%0d: step=%b want 0", k, step);
            end
        end
        n_vec++;
        if (digit !== 8'h01) begin
            n_err++;
            $display("FAIL bounce_digit: digit=%h want 01", digit);
        end
    endtask

    task automatic check_press(input string name, input logic dir,
                               input logic [7:0] exp_digit, input int exp_wraps);
        int s;
        int w;
        up = dir;
        do_press(s, w);
        n_vec++;
        if (s !== 1 || w !== exp_wraps || digit !== exp_digit) begin
            n_err++;
            $display("FAIL %s: steps=%0d wraps=%0d digit=%h, want 1 %0d %h",
                     name, s, w, digit, exp_wraps, exp_digit);
        end
    endtask

    task automatic test_wrap;
        do_load(8'h99);
        check_press("wrap_up_99", 1'b1, 8'h00, 1);
        check_press("wrap_down_00", 1'b0, 8'h99, 1);
        do_load(8'h19);
        check_press("carry_19", 1'b1, 8'h20, 0);
        check_press("borrow_20", 1'b0, 8'h19, 0);
        do_load(8'h09);
        check_press("carry_09", 1'b1, 8'h10, 0);
    endtask

    task automatic test_load_priority;
        int s;
        s     = 0;
        up    = 1'b1;
        do_load(8'h00);
        key_n = 1'b0;
        for (int k = 1; k <= 6; k++) tick();
        load_val = 8'hA3;
        load     = 1'b1;
        tick();
        load     = 1'b0;
        n_vec++;
        if (digit !== 8'h93 || step !== 1'b0) begin
            n_err++;
            $display("FAIL load_priority: digit=%h step=%b want 93 0", digit, step);
        end
        for (int k = 0; k < 5; k++) begin
            tick();
            if (step === 1'b1) s++;
        end
        key_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (step === 1'b1) s++;
        end
        n_vec++;
        if (s !== 0 || digit !== 8'h93) begin
            n_err++;
            $display("FAIL load_drops_press: steps=%0d digit=%h want 0 93", s, digit);
        end
    endtask

    task automatic test_clamp;
        do_load(8'hFF);
        n_vec++;
        if (digit !== 8'h99) begin
            n_err++;
            $display("FAIL clamp_FF: digit=%h want 99", digit);
        end
        do_load(8'h5C);
        n_vec++;
        if (digit !== 8'h59) begin
            n_err++;
            $display("FAIL clamp_5C: digit=%h want 59", digit);
        end
    endtask

    task automatic test_reset_mid_debounce;
        int s;
        s = 0;
        do_load(8'h42);
        key_n = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        #2 rst_n = 1'b0;
        key_n = 1'b1;
        #2 rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (step === 1'b1) s++;
        end
        n_vec++;
        if (s !== 0 || digit !== 8'h00) begin
            n_err++;
            $display("FAIL reset_mid_debounce: steps=%0d digit=%h want 0 00", s, digit);
        end
    endtask

`ifdef KEY_BCD_AUTOREPEAT_EN
    task automatic test_autorepeat;
        logic exp;
        do_load(8'h00);
        up    = 1'b1;
        key_n = 1'b0;
        for (int k = 1; k <= 90; k++) begin
            tick();
            exp = (k == 7) || (k == 39) || (k == 71);
            n_vec++;
            if (step !== exp) begin
                n_err++;
                $display("FAIL autorepeat_c%0d: step=%b want %b", k, step, exp);
            end
        end
        key_n = 1'b1;
        for (int k = 0; k < 12; k++) tick();
        n_vec++;
        if (digit !== 8'h03) begin
            n_err++;
            $display("FAIL autorepeat_digit: digit=%h want 03", digit);
        end
    endtask
`endif

    initial begin
        n_vec    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        key_n    = 1'b1;
        up       = 1'b1;
        load     = 1'b0;
        load_val = 8'h00;
        test_reset();
        test_async_reset();
        test_single_press();
        test_bounce();
        test_wrap();
        test_load_priority();
        test_clamp();
        test_reset_mid_debounce();
`ifdef KEY_BCD_AUTOREPEAT_EN
        test_autorepeat();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
